pcpu_imem_loader: RTL
=====================

# pcpu_imem_loader

Boot-time instruction loader and instruction memory for `pcpu`. It sits directly upstream of the CPU's fetch port. It receives a byte stream over a valid/ready link and assembles it into 16-bit instruction words. It writes the words into a 256×16 instruction RAM, checks a checksum, and on success releases the CPU with `enable` and a one-cycle `start` pulse. After that it serves `i_addr` → `i_datain` fetches.

## Interface
- `AW`, default 8: instruction address width; RAM depth is 2^AW.
- `DW`, default 16: instruction word width; must be 16, loaded as two bytes.
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state except RAM contents.
- `load_req`, in, 1: request a new load; one-cycle level sample.
- `in_valid`, in, 1: byte on `in_byte` is valid.
- `in_byte`, in, 8: stream byte.
- `in_ready`, out, 1: loader accepts a byte this cycle.
- `i_addr`, in, AW: fetch address from `pcpu`.
- `i_datain`, out, DW: instruction to `pcpu`; combinational `mem[i_addr]`.
- `cpu_enable`, out, 1: drives `pcpu.enable`.
- `cpu_start`, out, 1: drives `pcpu.start`; one-cycle pulse.
- `busy`, out, 1: a load is in progress.
- `err`, out, 1: the last load failed its checksum.

## Operation
- Stream format, in order:
  - one count byte N; 0 means 256 words.
  - then N words, each as high byte then low byte.
  - then one checksum byte equal to the XOR of all 2N data bytes. The count byte is excluded.
- A byte transfers on a rising edge where `in_valid && in_ready`.
- FSM states: `IDLE`, `COUNT`, `HI`, `LO`, `CSUM`, `START`, `RUN`, `ERR`.
- `IDLE`/`RUN`/`ERR` with `load_req`=1 → `COUNT`. This clears `wptr` and `csum`, and clears `err`.
- `COUNT`: on transfer, latch `cnt` = (byte==0 ? 256 : byte), a 9-bit value → `HI`.
- `HI`: on transfer, latch `hi` and set `csum ^= byte` → `LO`.
- `LO`: on transfer:
  - write `mem[wptr] <= {hi, byte}`, set `csum ^= byte`, `wptr++`.
  - if `wptr == cnt-1` (pre-increment) → `CSUM`, else → `HI`.
- `CSUM`: on transfer, if `byte == csum` → `START`, else → `ERR`.
- `START`: go to `RUN` unconditionally after 1 cycle.
- `RUN`: hold until `load_req`.
- `ERR`: hold until `load_req`.
- `in_ready` = 1 exactly in `COUNT`, `HI`, `LO`, `CSUM`.
- `busy` = 1 exactly in `COUNT`, `HI`, `LO`, `CSUM`, `START`.
- `cpu_start` = 1 exactly in `START`.
- `cpu_enable` = 1 in `START` and `RUN`; 0 elsewhere, so the CPU is frozen while loading or after an error.
- `err` = 1 exactly in `ERR`.
- `load_req` is ignored while `busy`. It is not queued.
- `wptr` is AW bits wide. A 256-word load ends at `wptr` wrapping 0xFF → 0x00; no out-of-range write can occur.
- RAM locations not written by the current load keep their previous contents. RAM has no reset.
- Reset at any point, including mid-load, gives:
  - state `IDLE`, `wptr`=0, `csum`=0, `cnt`=0, `hi`=0.
  - all outputs low except `i_datain`.
  - Partially written RAM words remain.

## Timing
- Reset values: `in_ready`=0, `cpu_enable`=0, `cpu_start`=0, `busy`=0, `err`=0.
- `i_datain` has zero-cycle latency from `i_addr`. There is no clock between address and data.
- `load_req` high at edge k → `in_ready`=1 from cycle k+1.
- One byte can be accepted per cycle. A full load takes 2N+2 transfer cycles minimum.
- Last RAM write (`LO` transfer) at edge t: the word is readable via `i_datain` from cycle t+1.
- Checksum byte accepted at edge c:
  - on a match, `cpu_start`=1 and `cpu_enable`=1 during cycle c+1. `cpu_start`=0 and `cpu_enable`=1 from c+2.
  - on a mismatch, `err`=1 from cycle c+1. `cpu_enable` stays 0.
- `in_valid` may be held low for any number of cycles in any loading state. State and registers hold, with no timeout.
- `load_req` in `RUN` drops `cpu_enable` on the next cycle.

## Test plan
- Nominal load: `load_req`, then bytes 02,12,34,AB,CD,40.
  - RAM[0]=1234, RAM[1]=ABCD; `i_addr`=1 gives `i_datain`=ABCD.
  - `cpu_start` pulses exactly one cycle after byte 40; `cpu_enable` stays 1.
- Bad checksum: same stream with checksum 41.
  - `err`=1, `cpu_enable`=0, `cpu_start` never asserted.
  - Next `load_req` clears `err` and `in_ready`=1.
- Backpressure/gaps: nominal stream with `in_valid` low 3 cycles between every byte. Results are identical to the nominal load.
- Count 0: 256 words where word i = {i, ~i}, plus the correct checksum (00).
  - RAM[FF]=FF00; `wptr` wraps to 0; `cpu_start` pulses.
- Reset mid-load: assert `reset` after byte 34 of the nominal load.
  - All outputs 0 asynchronously; FSM is `IDLE`; RAM[0]=1234 retained.
  - A subsequent full nominal load succeeds.
- Reload during `RUN` and ignored request:
  - `load_req` in `RUN` → `cpu_enable`=0 the next cycle.
  - `load_req` pulsed during `HI` has no effect on state.

Source files
------------

// File: rtl/pcpu_imem_loader.sv
// Boot loader + 2^AW x DW instruction RAM feeding pcpu fetch; releases the CPU after a checksum-verified byte-stream load.
// Latency: i_datain is combinational from i_addr; cpu_start pulses one cycle after the checksum byte is accepted.
// Backpressure: in_ready is high only in COUNT/HI/LO/CSUM; in_valid gaps of any length simply stall the FSM.
//
// Ports:
//   clock, reset         single clock, async active-high reset (RAM contents are not reset)
//   load_req             start a new load from IDLE/RUN/ERR; ignored while busy
//   in_valid/in_byte     byte stream: count N (0 => 256), N words hi/lo, XOR checksum of data bytes
//   in_ready             loader accepts a byte this cycle
//   i_addr/i_datain      CPU fetch port, i_datain = mem[i_addr]
//   cpu_enable/cpu_start CPU release controls; start is a one-cycle pulse
//   busy, err            load in progress / last load failed its checksum
module pcpu_imem_loader #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_req,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  output logic          in_ready,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_datain,
  output logic          cpu_enable,
  output logic          cpu_start,
  output logic          busy,
  output logic          err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] COUNT = 3'd1;
  localparam logic [2:0] HI    = 3'd2;
  localparam logic [2:0] LO    = 3'd3;
  localparam logic [2:0] CSUM  = 3'd4;
  localparam logic [2:0] START = 3'd5;
  localparam logic [2:0] RUN   = 3'd6;
  localparam logic [2:0] ERR   = 3'd7;

  logic [2:0]    state;
  logic [AW-1:0] wptr;
  logic [7:0]    csum;
  logic [8:0]    cnt;
  logic [7:0]    hi;
  logic          xfer;
  logic          last_word;

  logic [DW-1:0] mem [2**AW];

  assign xfer = in_valid && in_ready;

  // Compared before the increment, so a 256-word load terminates exactly
  // as wptr wraps 0xFF -> 0x00 and never addresses outside the RAM.
  assign last_word = (9'(wptr) == (cnt - 9'd1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wptr  <= '0;
      csum  <= '0;
      cnt   <= '0;
      hi    <= '0;
    end else begin
      case (state)
        IDLE, RUN, ERR: begin
          if (load_req) begin
            state <= COUNT;
            wptr  <= '0;
            csum  <= '0;
          end
        end
        COUNT: begin
          if (xfer) begin
            cnt   <= (in_byte == 8'd0) ? 9'd256 : {1'b0, in_byte};
            state <= HI;
          end
        end
        HI: begin
          if (xfer) begin
            hi    <= in_byte;
            csum  <= csum ^ in_byte;
            state <= LO;
          end
        end
        LO: begin
          if (xfer) begin
            csum  <= csum ^ in_byte;
            wptr  <= wptr + AW'(1);
            state <= last_word ? CSUM : HI;
          end
        end
        CSUM: begin
          if (xfer) begin
            state <= (in_byte == csum) ? START : ERR;
          end
        end
        START:   state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM has no reset; words written before a reset or by earlier loads persist.
  always_ff @(posedge clock) begin
    if (state == LO && xfer) begin
      mem[wptr] <= {hi, in_byte};
    end
  end

  assign i_datain   = mem[i_addr];
  assign in_ready   = (state == COUNT) || (state == HI) || (state == LO) || (state == CSUM);
  assign busy       = in_ready || (state == START);
  assign cpu_start  = (state == START);
  assign cpu_enable = (state == START) || (state == RUN);
  assign err        = (state == ERR);

endmodule
